// File: rtl/snoop_bus_arbiter.sv
// ============================================================================
// Module      : snoop_bus_arbiter
// Description : Round-robin arbiter for a snooping coherence bus. It grants one
//               cache, broadcasts a one-cycle snoop to every other cache, runs
//               the memory phase when needed, and returns a done pulse.
//               Optional macro ARB_TIMEOUT_EN adds a watchdog on the memory wait.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snoop_bus_arbiter #(
  parameter int N       = 2,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N-1:0][1:0]     req_op,
  input  logic [ADDR_W-1:0]     req_addr [N],
  output logic [N-1:0]          gnt,
  output logic [N-1:0]          done,
  output logic                  bus_busy,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [1:0]            bus_op,
  output logic [N-1:0]          snoop_read,
  output logic [N-1:0]          snoop_read_excl,
  output logic [N-1:0]          snoop_invalidate,
  output logic                  mem_req,
  input  logic                  mem_ack,
  output logic                  timeout_err
);

  localparam int       c_idx_w   = $clog2(N);
  localparam logic [1:0] c_op_rdx  = 2'b10;
  localparam logic [1:0] c_op_upgr = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SNOOP = 2'd1,
    ST_MEM   = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_idx_w-1:0]   r_last;
  logic [c_idx_w-1:0]   w_cand;
  logic [c_idx_w-1:0]   w_win_idx;
  logic [N-1:0]         w_win_oh;
  logic [1:0]           w_win_op;
  logic                 w_found;

`ifdef ARB_TIMEOUT_EN
  localparam int c_tmo_w = $clog2(TIMEOUT + 1);
  logic [c_tmo_w-1:0]   r_tmo_cnt;
`else
  // Without the watchdog the memory phase waits for mem_ack indefinitely.
  assign timeout_err = 1'b0;
`endif

  // Round-robin search starting just after the previous winner, with wrap.
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = '0;
    w_cand    = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = c_idx_w'((int'(r_last) + k) % N);
      if (!w_found && req[w_cand]) begin
        w_found   = 1'b1;
        w_win_idx = w_cand;
      end
    end
  end

  // One-hot form of the winner and its requested op.
  always_comb begin
    w_win_oh            = '0;
    w_win_oh[w_win_idx] = 1'b1;
    w_win_op            = req_op[w_win_idx];
  end

  // Transaction FSM; every bus-facing output is registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= ST_IDLE;
      r_last           <= c_idx_w'(N - 1);
      gnt              <= '0;
      done             <= '0;
      bus_busy         <= 1'b0;
      bus_addr         <= '0;
      bus_op           <= '0;
      snoop_read       <= '0;
      snoop_read_excl  <= '0;
      snoop_invalidate <= '0;
      mem_req          <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      timeout_err      <= 1'b0;
      r_tmo_cnt        <= '0;
`endif
    end else begin
      // Pulse outputs default low; states below raise them for one cycle.
      snoop_read       <= '0;
      snoop_read_excl  <= '0;
      snoop_invalidate <= '0;
      done             <= '0;
`ifdef ARB_TIMEOUT_EN
      timeout_err      <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state  <= ST_SNOOP;
            bus_busy <= 1'b1;
            gnt      <= w_win_oh;
            bus_addr <= req_addr[w_win_idx];
            bus_op   <= w_win_op;
            // Reserved op 00 falls into the BusRd (default) branch.
            case (w_win_op)
              c_op_rdx:  snoop_read_excl  <= ~w_win_oh;
              c_op_upgr: snoop_invalidate <= ~w_win_oh;
              default:   snoop_read       <= ~w_win_oh;
            endcase
          end
        end
        ST_SNOOP: begin
          if (bus_op == c_op_upgr) begin
            // Upgrade needs no data, so skip the memory phase.
            r_state <= ST_RESP;
            done    <= gnt;
          end else begin
            r_state <= ST_MEM;
            mem_req <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
          end
        end
        ST_MEM: begin
          if (mem_ack) begin
            r_state <= ST_RESP;
            mem_req <= 1'b0;
            done    <= gnt;
          end
`ifdef ARB_TIMEOUT_EN
          else if (r_tmo_cnt == c_tmo_w'(TIMEOUT - 1)) begin
            r_state     <= ST_RESP;
            mem_req     <= 1'b0;
            done        <= gnt;
            timeout_err <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          r_state  <= ST_IDLE;
          r_last   <= w_win_idx_hold(gnt);
          gnt      <= '0;
          bus_busy <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Index of the set bit in the (one-hot) grant vector.
  function automatic logic [c_idx_w-1:0] w_win_idx_hold(input logic [N-1:0] oh);
    logic [c_idx_w-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx = c_idx_w'(i);
    end
    return idx;
  endfunction

endmodule

`default_nettype wire

// File: tb/tb_snoop_bus_arbiter.sv
// ============================================================================
// Module      : tb_snoop_bus_arbiter
// Description : Self-checking bench for snoop_bus_arbiter (N=2). Table-driven
//               transactions plus hand sequences for address stability,
//               mid-transaction reset and (with ARB_TIMEOUT_EN) the watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_snoop_bus_arbiter;

  logic              clk;
  logic              rst;
  logic [1:0]        req;
  logic [1:0][1:0]   req_op;
  logic [31:0]       req_addr [2];
  logic [1:0]        gnt;
  logic [1:0]        done;
  logic              bus_busy;
  logic [31:0]       bus_addr;
  logic [1:0]        bus_op;
  logic [1:0]        snoop_read;
  logic [1:0]        snoop_read_excl;
  logic [1:0]        snoop_invalidate;
  logic              mem_req;
  logic              mem_ack;
  logic              timeout_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  op0;
    logic [1:0]  op1;
    logic [31:0] a0;
    logic [31:0] a1;
    int          dly;
    logic [1:0]  gnt;
  } vec_t;

  typedef struct {
    logic [1:0]  done;
    logic [31:0] addr;
    logic [1:0]  op;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];

  snoop_bus_arbiter #(.N(2), .ADDR_W(32), .TIMEOUT(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .req_op           (req_op),
    .req_addr         (req_addr),
    .gnt              (gnt),
    .done             (done),
    .bus_busy         (bus_busy),
    .bus_addr         (bus_addr),
    .bus_op           (bus_op),
    .snoop_read       (snoop_read),
    .snoop_read_excl  (snoop_read_excl),
    .snoop_invalidate (snoop_invalidate),
    .mem_req          (mem_req),
    .mem_ack          (mem_ack),
    .timeout_err      (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] d, input logic [31:0] a, input logic [1:0] op);
    exp_t e;
    e.done = d;
    e.addr = a;
    e.op   = op;
    sb.push_back(e);
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always begin
    @(posedge clk);
    #1;
    if (done !== 2'b00) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_done actual=%0h required=0", done);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_done", 64'(done), 64'(e.done));
        chk("sb_addr", 64'(bus_addr), 64'(e.addr));
        chk("sb_op", 64'(bus_op), 64'(e.op));
      end
    end
  end

  // One full transaction from a table record; starts and ends in an IDLE cycle.
  task automatic run_vec(input vec_t v);
    logic [1:0]  opw;
    logic [31:0] aw;
    logic [1:0]  lose;
    logic [1:0]  e_rd;
    logic [1:0]  e_rdx;
    logic [1:0]  e_inv;
    opw   = v.gnt[0] ? v.op0 : v.op1;
    aw    = v.gnt[0] ? v.a0 : v.a1;
    lose  = ~v.gnt;
    e_rd  = (opw == 2'b01 || opw == 2'b00) ? lose : 2'b00;
    e_rdx = (opw == 2'b10) ? lose : 2'b00;
    e_inv = (opw == 2'b11) ? lose : 2'b00;
    req_op[0]   = v.op0;
    req_op[1]   = v.op1;
    req_addr[0] = v.a0;
    req_addr[1] = v.a1;
    req         = v.req;
    push_exp(v.gnt, aw, opw);
    tick();
    chk("gnt_t1", 64'(gnt), 64'(v.gnt));
    chk("snoop_read_t1", 64'(snoop_read), 64'(e_rd));
    chk("snoop_rdx_t1", 64'(snoop_read_excl), 64'(e_rdx));
    chk("snoop_inv_t1", 64'(snoop_invalidate), 64'(e_inv));
    chk("busy_t1", 64'(bus_busy), 64'd1);
    chk("bus_addr_t1", 64'(bus_addr), 64'(aw));
    tick();
    chk("snoop_clear_t2", 64'({snoop_read, snoop_read_excl, snoop_invalidate}), 64'd0);
    if (opw == 2'b11) begin
      chk("upgr_no_memreq", 64'(mem_req), 64'd0);
      chk("upgr_done_t2", 64'(done), 64'(v.gnt));
    end else begin
      chk("mem_req_t2", 64'(mem_req), 64'd1);
      chk("no_done_t2", 64'(done), 64'd0);
      repeat (v.dly) begin
        tick();
        chk("mem_req_hold", 64'(mem_req), 64'd1);
        chk("no_done_wait", 64'(done), 64'd0);
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("done_after_ack", 64'(done), 64'(v.gnt));
      chk("mem_req_drop", 64'(mem_req), 64'd0);
    end
    req = req & ~v.gnt;
    chk("gnt_resp", 64'(gnt), 64'(v.gnt));
    tick();
    chk("gnt_idle", 64'(gnt), 64'd0);
    chk("busy_idle", 64'(bus_busy), 64'd0);
    chk("done_idle", 64'(done), 64'd0);
  endtask

  // Hard stop in case the run ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b0;
    req         = '0;
    req_op      = '0;
    req_addr[0] = '0;
    req_addr[1] = '0;
    mem_ack     = 1'b0;

    //          req    op0    op1    a0         a1         dly gnt
    vecs[0] = '{2'b01, 2'b01, 2'b00, 32'h100, 32'h000, 3, 2'b01};
    vecs[1] = '{2'b11, 2'b10, 2'b10, 32'h110, 32'h120, 1, 2'b10};
    vecs[2] = '{2'b11, 2'b10, 2'b10, 32'h110, 32'h120, 2, 2'b01};
    vecs[3] = '{2'b11, 2'b10, 2'b10, 32'h110, 32'h120, 0, 2'b10};
    vecs[4] = '{2'b10, 2'b00, 2'b11, 32'h000, 32'h300, 0, 2'b10};
    vecs[5] = '{2'b01, 2'b00, 2'b01, 32'h140, 32'h000, 0, 2'b01};
    vecs[6] = '{2'b11, 2'b11, 2'b01, 32'h150, 32'h160, 1, 2'b10};

    repeat (2) tick();
    chk("rst_outs", 64'({gnt, done, snoop_read, snoop_read_excl, snoop_invalidate,
                         mem_req, bus_busy, timeout_err, bus_op}), 64'd0);
    chk("rst_bus_addr", 64'(bus_addr), 64'd0);
    rst = 1'b1;
    tick();

    // mem_ack while idle must be ignored.
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("ack_in_idle", 64'({bus_busy, mem_req, done, gnt}), 64'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Winner drops req and the request fields change during MEM.
    req_op[0]   = 2'b01;
    req_addr[0] = 32'h100;
    req         = 2'b01;
    push_exp(2'b01, 32'h100, 2'b01);
    tick();
    chk("hold_gnt", 64'(gnt), 64'd1);
    req = 2'b00;
    tick();
    chk("hold_mem_req", 64'(mem_req), 64'd1);
    req_addr[0] = 32'h200;
    req_op[0]   = 2'b10;
    repeat (2) begin
      tick();
      chk("hold_bus_addr", 64'(bus_addr), 64'h100);
      chk("hold_bus_op", 64'(bus_op), 64'd1);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("hold_done", 64'(done), 64'd1);
    tick();
    chk("hold_idle", 64'(bus_busy), 64'd0);

    // Reset in the middle of MEM aborts the transaction with no done.
    req_op[1]   = 2'b01;
    req_addr[1] = 32'h180;
    req         = 2'b10;
    tick();
    chk("abort_gnt", 64'(gnt), 64'd2);
    tick();
    chk("abort_mem_req", 64'(mem_req), 64'd1);
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("abort_outs", 64'({gnt, done, snoop_read, snoop_read_excl, snoop_invalidate,
                           mem_req, bus_busy, timeout_err, bus_op}), 64'd0);
    chk("abort_bus_addr", 64'(bus_addr), 64'd0);
    req = 2'b00;
    repeat (2) tick();
    chk("abort_no_done", 64'(done), 64'd0);
    #2;
    rst = 1'b1;
    tick();
    run_vec('{2'b11, 2'b01, 2'b01, 32'h400, 32'h410, 1, 2'b01});

`ifdef ARB_TIMEOUT_EN
    // Memory never answers: watchdog fires 16 cycles after MEM entry.
    req_op[0]   = 2'b01;
    req_addr[0] = 32'h500;
    req         = 2'b01;
    push_exp(2'b01, 32'h500, 2'b01);
    tick();
    chk("tmo_gnt", 64'(gnt), 64'd1);
    tick();
    chk("tmo_mem_req", 64'(mem_req), 64'd1);
    repeat (15) begin
      tick();
      chk("tmo_early", 64'({timeout_err, done}), 64'd0);
    end
    tick();
    chk("tmo_err", 64'(timeout_err), 64'd1);
    chk("tmo_done", 64'(done), 64'd1);
    chk("tmo_mem_req_drop", 64'(mem_req), 64'd0);
    req = 2'b00;
    tick();
    chk("tmo_err_clear", 64'(timeout_err), 64'd0);
    chk("tmo_idle", 64'(bus_busy), 64'd0);
`endif

    tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
